// File: rtl/fan_pwm_driver.sv
// fan_pwm_driver: fan speed PWM generator with period-boundary duty ramping,
// tachometer stall detection with a latched fault, and a rate-limited
// cooler enable.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   fan_status    requested speed: 00 off, 01 low (40%), 10 medium (70%), 11 high (100%)
//   cooler_status requested cooler state
//   tach_in       asynchronous tachometer pulse from the fan
//   fault_clear   single-cycle stall-fault acknowledge
//   fan_pwm       registered PWM drive, high while period counter < duty
//   cooler_on     registered cooler drive, changes at most once per COOLER_HOLD cycles
//   duty          current duty in percent, 0..100
//   state         00 OFF, 01 RAMP, 10 HOLD, 11 FAULT
//   fault         latched stall fault
module fan_pwm_driver #(
   parameter int unsigned CLOCK_FREQUENCY = 10000,
   parameter int unsigned RAMP_STEP       = 10,
   parameter int unsigned TACH_TIMEOUT    = CLOCK_FREQUENCY / 2,
   parameter int unsigned COOLER_HOLD     = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] fan_status,
   input  logic       cooler_status,
   input  logic       tach_in,
   input  logic       fault_clear,
   output logic       fan_pwm,
   output logic       cooler_on,
   output logic [6:0] duty,
   output logic [1:0] state,
   output logic       fault
);

   localparam int unsigned PERIOD  = 100;
   localparam int unsigned CNT_W   = 7;
   localparam int unsigned DUTY_W  = 7;
   localparam int unsigned RAMP_W  = 8;
   localparam int unsigned STALL_W = (TACH_TIMEOUT < 2) ? 1 : $clog2(TACH_TIMEOUT);
   localparam int unsigned HOLD_W  = (COOLER_HOLD < 1) ? 1 : $clog2(COOLER_HOLD + 1);

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_RAMP  = 2'b01,
      ST_HOLD  = 2'b10,
      ST_FAULT = 2'b11
   } state_t;

   logic [CNT_W-1:0]   r_cnt;
   logic [DUTY_W-1:0]  r_duty;
   logic [DUTY_W-1:0]  r_target;
   logic               r_pwm;
   logic               r_fault;
   logic [STALL_W-1:0] r_stall;
   logic               r_tach_s1;
   logic               r_tach_s2;
   logic               r_tach_d;
   logic               r_cooler;
   logic [HOLD_W-1:0]  r_hold;

   logic               w_bound;
   logic               w_tach_rise;
   logic               w_timeout;
   logic [DUTY_W-1:0]  w_target;
   logic [RAMP_W-1:0]  w_up;
   logic [RAMP_W-1:0]  w_dn;
   logic [DUTY_W-1:0]  w_ramp;
   state_t             w_state;

   assign w_bound     = (r_cnt == CNT_W'(PERIOD - 1));
   assign w_tach_rise = r_tach_s2 & ~r_tach_d;
   // Stall fires on the cycle the timer would reach the limit; a tach edge that same cycle rescues it.
   assign w_timeout   = ~r_fault && (r_duty != '0) && ~w_tach_rise &&
                        (r_stall == STALL_W'(TACH_TIMEOUT - 1));

   // Requested speed to duty percentage
   always_comb begin
      w_target = '0;
      case (fan_status)
         2'b00:   w_target = DUTY_W'(0);
         2'b01:   w_target = DUTY_W'(40);
         2'b10:   w_target = DUTY_W'(70);
         default: w_target = DUTY_W'(100);
      endcase
   end

   // One ramp step toward target, clamped so it never passes the target
   always_comb begin
      w_up   = RAMP_W'(r_duty) + RAMP_W'(RAMP_STEP);
      w_dn   = (RAMP_W'(r_duty) >= RAMP_W'(RAMP_STEP)) ?
               (RAMP_W'(r_duty) - RAMP_W'(RAMP_STEP)) : '0;
      w_ramp = r_duty;
      if (r_duty < r_target) begin
         w_ramp = (w_up > RAMP_W'(r_target)) ? r_target : DUTY_W'(w_up);
      end else if (r_duty > r_target) begin
         w_ramp = (w_dn < RAMP_W'(r_target)) ? r_target : DUTY_W'(w_dn);
      end
   end

   // Reported state, derived from registered values only
   always_comb begin
      w_state = ST_HOLD;
      if (r_fault) begin
         w_state = ST_FAULT;
      end else if ((r_duty == '0) && (r_target == '0)) begin
         w_state = ST_OFF;
      end else if (r_duty != r_target) begin
         w_state = ST_RAMP;
      end
   end

   // PWM period counter and registered PWM compare
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_pwm <= 1'b0;
      end else begin
         r_cnt <= w_bound ? '0 : r_cnt + CNT_W'(1);
         r_pwm <= (r_cnt < r_duty);
      end
   end

   // Latched target; duty only moves at the period boundary and is held at 0 while faulted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_target <= '0;
         r_duty   <= '0;
      end else begin
         r_target <= w_target;
         if (w_timeout || r_fault) begin
            r_duty <= '0;
         end else if (w_bound) begin
            r_duty <= w_ramp;
         end
      end
   end

   // Tach synchronizer and rising-edge history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tach_s1 <= 1'b0;
         r_tach_s2 <= 1'b0;
         r_tach_d  <= 1'b0;
      end else begin
         r_tach_s1 <= tach_in;
         r_tach_s2 <= r_tach_s1;
         r_tach_d  <= r_tach_s2;
      end
   end

   // Stall timer and fault latch; timeout takes priority over an acknowledge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall <= '0;
         r_fault <= 1'b0;
      end else begin
         if (r_fault || (r_duty == '0) || w_tach_rise || w_timeout) begin
            r_stall <= '0;
         end else begin
            r_stall <= r_stall + STALL_W'(1);
         end
         if (w_timeout) begin
            r_fault <= 1'b1;
         end else if (fault_clear) begin
            r_fault <= 1'b0;
         end
      end
   end

   // Cooler follows its request only once the hold time since the last change has elapsed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cooler <= 1'b0;
         r_hold   <= HOLD_W'(COOLER_HOLD);
      end else if (r_hold == HOLD_W'(COOLER_HOLD)) begin
         if (cooler_status != r_cooler) begin
            r_cooler <= cooler_status;
            r_hold   <= '0;
         end
      end else begin
         r_hold <= r_hold + HOLD_W'(1);
      end
   end

   assign fan_pwm   = r_pwm;
   assign cooler_on = r_cooler;
   assign duty      = r_duty;
   assign state     = w_state;
   assign fault     = r_fault;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Testbench for fan_pwm_driver: table of ramp vectors, directed stall/cooler/reset
// sequences, then randomized stimulus against a behavioural reference model.
module tb_fan_pwm_driver;

   localparam int TACH_TIMEOUT = 5000;
   localparam int COOLER_HOLD  = 1000;
   localparam int RAMP_STEP    = 10;
   localparam int S_OFF = 0, S_RAMP = 1, S_HOLD = 2, S_FAULT = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] fan_status;
   logic       cooler_status;
   logic       tach_in;
   logic       fault_clear;
   logic       fan_pwm;
   logic       cooler_on;
   logic [6:0] duty;
   logic [1:0] state;
   logic       fault;

   fan_pwm_driver #(
      .CLOCK_FREQUENCY(10000),
      .RAMP_STEP      (RAMP_STEP),
      .TACH_TIMEOUT   (TACH_TIMEOUT),
      .COOLER_HOLD    (COOLER_HOLD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .fan_status   (fan_status),
      .cooler_status(cooler_status),
      .tach_in      (tach_in),
      .fault_clear  (fault_clear),
      .fan_pwm      (fan_pwm),
      .cooler_on    (cooler_on),
      .duty         (duty),
      .state        (state),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Tach generator: 0 = held low, 1 = pulse every 200 cycles, 2 = random short pulses
   int tach_mode = 0;
   int tach_ph   = 0;
   initial begin
      tach_in = 1'b0;
      forever begin
         @(negedge clk);
         case (tach_mode)
            1: begin
               tach_ph = (tach_ph + 1) % 200;
               tach_in = (tach_ph < 5);
            end
            2:       tach_in = ($urandom_range(0, 149) == 0);
            default: tach_in = 1'b0;
         endcase
      end
   end

   // ---------------- behavioural reference model ----------------
   int       m_n;         // cycles since reset; period position is m_n % 100
   int       m_duty;
   int       m_target;
   int       m_stall;
   int       m_cool_age;
   bit       m_fault;
   bit       m_cool;
   bit       m_pwm;
   bit [2:0] m_hist;      // tach_in as sampled at the last three edges, [0] newest

   function automatic int map_target(input logic [1:0] fs);
      case (fs)
         2'b00:   return 0;
         2'b01:   return 40;
         2'b10:   return 70;
         default: return 100;
      endcase
   endfunction

   function automatic int exp_state();
      if (m_fault) return S_FAULT;
      if (m_duty == 0 && m_target == 0) return S_OFF;
      if (m_duty != m_target) return S_RAMP;
      return S_HOLD;
   endfunction

   task automatic m_reset();
      m_n = 0; m_duty = 0; m_target = 0; m_stall = 0;
      m_cool_age = COOLER_HOLD; m_fault = 0; m_cool = 0; m_pwm = 0; m_hist = '0;
   endtask

   task automatic m_step();
      int phase;
      int nd;
      bit rise;
      bit tout;
      phase = m_n % 100;
      nd    = m_duty;
      // a tach level seen two and three edges ago marks a synchronized rising edge
      rise  = m_hist[1] && !m_hist[2];
      tout  = 0;
      m_pwm = (phase < m_duty);
      if (!m_fault && m_duty != 0 && !rise) begin
         if (m_stall + 1 >= TACH_TIMEOUT) begin
            tout    = 1;
            m_stall = 0;
         end else begin
            m_stall++;
         end
      end else begin
         m_stall = 0;
      end
      if (m_fault || tout) begin
         nd = 0;
      end else if (phase == 99) begin
         if (m_duty < m_target)
            nd = (m_duty + RAMP_STEP > m_target) ? m_target : m_duty + RAMP_STEP;
         else if (m_duty > m_target)
            nd = (m_duty - RAMP_STEP < m_target) ? m_target : m_duty - RAMP_STEP;
      end
      if (tout) m_fault = 1;
      else if (fault_clear) m_fault = 0;
      if (m_cool_age >= COOLER_HOLD && cooler_status != m_cool) begin
         m_cool     = cooler_status;
         m_cool_age = 0;
      end else if (m_cool_age < COOLER_HOLD) begin
         m_cool_age++;
      end
      m_duty   = nd;
      m_target = map_target(fan_status);
      m_hist   = {m_hist[1:0], tach_in};
      m_n++;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (reset) m_reset();
         else m_step();
      end
   end

   // ---------------- ramp vector table ----------------
   typedef struct {
      logic [1:0] fs;
      int         cycles;
      int         exp_duty;
      int         exp_state;
      int         exp_high;   // PWM-high samples over the row, -1 to skip
   } vec_t;

   vec_t vecs[$];

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int k;
      int hi;
      logic [11:0] got_v;
      logic [11:0] exp_v;
      int seg_left;

      for (int i = 0; i < 10; i++)
         vecs.push_back('{2'b11, 100, 10 * (i + 1), (i == 9) ? S_HOLD : S_RAMP, -1});
      vecs.push_back('{2'b11, 100, 100, S_HOLD, 100});
      for (int i = 0; i < 6; i++)
         vecs.push_back('{2'b01, 100, 90 - 10 * i, (i == 5) ? S_HOLD : S_RAMP, -1});
      vecs.push_back('{2'b01, 100, 40, S_HOLD, 40});

      reset = 1'b1; fan_status = 2'b00; cooler_status = 1'b0; fault_clear = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_duty",  duty,      0);
      check("reset_pwm",   fan_pwm,   0);
      check("reset_cool",  cooler_on, 0);
      check("reset_state", state,     S_OFF);
      check("reset_fault", fault,     0);

      // Ramp up to 100 then down to 40, one table row per PWM period
      fan_status = 2'b11; tach_mode = 1;
      reset = 1'b0;
      foreach (vecs[i]) begin
         fan_status = vecs[i].fs;
         hi = 0;
         repeat (vecs[i].cycles) begin
            @(negedge clk);
            if (fan_pwm) hi++;
         end
         check($sformatf("vec%0d_duty", i), duty, vecs[i].exp_duty);
         check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
         if (vecs[i].exp_high >= 0)
            check($sformatf("vec%0d_pwm_high", i), hi, vecs[i].exp_high);
      end

      // Stall timeout measured from the first nonzero duty, then acknowledge and restart
      fan_status = 2'b10; tach_mode = 0;
      do_reset();
      k = 0;
      while (duty == 0 && k < 200) begin @(negedge clk); k++; end
      check("stall_first_duty", duty, 10);
      k = 0;
      while (!fault && k < 6000) begin @(negedge clk); k++; end
      check("stall_cycles", k, TACH_TIMEOUT);
      check("stall_state", state, S_FAULT);
      check("stall_duty", duty, 0);
      @(negedge clk);
      check("stall_pwm_next", fan_pwm, 0);
      fault_clear = 1'b1;
      @(negedge clk);
      fault_clear = 1'b0;
      check("clear_fault", fault, 0);
      check("clear_state", state, S_RAMP);
      tach_mode = 1;
      k = 0;
      while (duty == 0 && k < 150) begin @(negedge clk); k++; end
      check("restart_duty", duty, 10);

      // Acknowledge on the very cycle of the timeout loses
      fan_status = 2'b10; tach_mode = 0;
      do_reset();
      k = 0;
      while (duty == 0 && k < 200) begin @(negedge clk); k++; end
      repeat (TACH_TIMEOUT - 1) @(negedge clk);
      check("pre_timeout_fault", fault, 0);
      fault_clear = 1'b1;
      @(negedge clk);
      fault_clear = 1'b0;
      check("timeout_wins", fault, 1);
      repeat (3) @(negedge clk);
      check("fault_sticky", fault, 1);

      // Cooler hold: immediate first change, later change deferred until the hold expires
      fan_status = 2'b00; tach_mode = 0;
      do_reset();
      repeat (10) @(negedge clk);
      cooler_status = 1'b1;
      @(negedge clk);
      check("cool_rise", cooler_on, 1);
      for (int j = 1; j <= 1001; j++) begin
         @(negedge clk);
         if (j == 200) begin
            check("cool_hold200", cooler_on, 1);
            cooler_status = 1'b0;
         end
         if (j == 1000) check("cool_hold1000", cooler_on, 1);
         if (j == 1001) check("cool_fall", cooler_on, 0);
      end

      // Asynchronous reset in the middle of a ramp
      fan_status = 2'b11; tach_mode = 1; cooler_status = 1'b1;
      do_reset();
      k = 0;
      while (duty != 50 && k < 700) begin @(negedge clk); k++; end
      check("mid_reach50", duty, 50);
      check("mid_cool_on", cooler_on, 1);
      #2 reset = 1'b1;
      #1;
      check("async_duty",  duty,      0);
      check("async_pwm",   fan_pwm,   0);
      check("async_cool",  cooler_on, 0);
      check("async_state", state,     S_OFF);
      check("async_fault", fault,     0);

      // Randomized run against the reference model
      @(negedge clk);
      fan_status = 2'($urandom_range(0, 3)); cooler_status = 1'b0; fault_clear = 1'b0;
      tach_mode = 2; seg_left = 3000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 30000; c++) begin
         @(negedge clk);
         got_v = {fan_pwm, cooler_on, duty, state, fault};
         exp_v = {m_pwm, m_cool, 7'(m_duty), 2'(exp_state()), m_fault};
         n_tests++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL model cyc %0d: got pwm=%0b cool=%0b duty=%0d state=%0d fault=%0b, expected pwm=%0b cool=%0b duty=%0d state=%0d fault=%0b",
                     c, fan_pwm, cooler_on, duty, state, fault,
                     m_pwm, m_cool, m_duty, exp_state(), m_fault);
         end
         if (seg_left == 0) begin
            tach_mode = ($urandom_range(0, 9) < 7) ? 2 : 0;
            seg_left  = (tach_mode == 0) ? $urandom_range(1000, 7000) : $urandom_range(500, 4000);
         end else begin
            seg_left--;
         end
         if ($urandom_range(0, 149) == 0) fan_status = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) cooler_status = ~cooler_status;
         fault_clear = ($urandom_range(0, 199) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fan_pwm_driver.md
FAN_PWM_DRIVER -- requirements
Module: fan_pwm_driver

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 10000, clock rate in Hz.
REQ-002 SHALL have parameter RAMP_STEP, default 10, duty change (percent) per PWM period.
REQ-003 SHALL have parameter TACH_TIMEOUT, default CLOCK_FREQUENCY/2, stall limit in clock cycles.
REQ-004 SHALL have parameter COOLER_HOLD, default 1000, minimum clock cycles between cooler_on changes.
REQ-005 SHALL have port clk  input  1  single system clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port fan_status  input  2  requested speed: 00 off, 01 low, 10 medium, 11 high.
REQ-008 SHALL have port cooler_status  input  1  requested cooler state.
REQ-009 SHALL have port tach_in  input  1  asynchronous fan tachometer pulse.
REQ-010 SHALL have port fault_clear  input  1  single-cycle fault acknowledge.
REQ-011 SHALL have port fan_pwm  output  1  registered PWM drive.
REQ-012 SHALL have port cooler_on  output  1  registered cooler drive.
REQ-013 SHALL have port duty  output  7  current duty, 0..100 percent.
REQ-014 SHALL have port state  output  2  00 OFF, 01 RAMP, 10 HOLD, 11 FAULT.
REQ-015 SHALL have port fault  output  1  stall fault latched.

Function
REQ-016 SHALL map fan_status to target duty: 00->0, 01->40, 10->70, 11->100.
REQ-017 SHALL run a period counter 0..99, incrementing every clk and wrapping 99->0.
REQ-018 SHALL drive fan_pwm = (counter < duty), registered; duty 0 gives constant low, duty 100 gives constant high.
REQ-019 SHALL update duty only on the cycle where the counter equals 99 (the period boundary), so target changes mid-period take effect at the next boundary.
REQ-020 At the boundary, SHALL set duty to min(duty+RAMP_STEP, target) when duty<target, max(duty-RAMP_STEP, target) when duty>target, and leave it unchanged when equal.
REQ-021 SHALL compute ramp arithmetic 8 bits wide, unsigned, with no overflow or underflow past target.
REQ-022 SHALL derive state as: FAULT if fault=1; else OFF if duty=0 and target=0; else RAMP if duty!=target; else HOLD.
REQ-023 SHALL synchronize tach_in through two flops and detect rising edges on the synchronized signal.
REQ-024 SHALL count a stall timer while duty!=0 and fault=0; clear it on a tach rising edge and hold it at 0 while duty=0.
REQ-025 When the stall timer reaches TACH_TIMEOUT, SHALL set fault=1, force duty=0 and fan_pwm=0 on the next cycle, and ignore target.
REQ-026 fault_clear SHALL clear fault and the stall timer, and ramping SHALL restart from duty 0 at the next boundary.
REQ-027 If fault_clear and the timeout occur in the same cycle, fault SHALL be set (timeout wins).
REQ-028 fault_clear while fault=0 SHALL have no effect.
REQ-029 SHALL run a saturating hold counter at COOLER_HOLD that clears to 0 on each cooler_on change.
REQ-030 SHALL copy cooler_status to cooler_on on the next cycle only when the hold counter equals COOLER_HOLD.
REQ-031 A cooler_status change made before the hold expires SHALL be deferred, applied once the hold expires if still differing, and dropped otherwise.
REQ-032 cooler_on SHALL be independent of fault.

Reset
REQ-033 While reset=1, SHALL asynchronously set fan_pwm=0, cooler_on=0, duty=0, state=00, fault=0, period counter=0, stall timer=0, tach synchronizers=0.
REQ-034 While reset=1, SHALL set the hold counter to COOLER_HOLD, so the first cooler request is honoured immediately.
REQ-035 Reset asserted mid-ramp or mid-hold SHALL force all outputs to their reset values without waiting for a clock edge.

Verification
REQ-036 Reset released with fan_status=11 and tach pulsing every 200 cycles -> duty becomes 10 at the first boundary, then rises by 10 each period to 100 after 10 periods; fan_pwm then stays high and state=10.
REQ-037 From duty 100, fan_status set to 01 -> duty steps 90, 80, ... 40 and stops at 40; fan_pwm is high for 40 of every 100 cycles; state goes 01 then 10.
REQ-038 fan_status=10 with tach_in held 0 -> fault=1 and state=11 exactly TACH_TIMEOUT=5000 cycles after duty first becomes nonzero, with fan_pwm=0 the next cycle; then fault_clear -> state 01 and ramping resumes from 0.
REQ-039 fault_clear pulsed on the same cycle as the timeout -> fault stays 1.
REQ-040 cooler_status rises 10 cycles after reset -> cooler_on=1 on the next cycle; cooler_status falls 200 cycles later -> cooler_on stays 1 until 1000 cycles after its rise, then goes 0.
REQ-041 reset pulsed mid-ramp at duty 50 -> duty, fan_pwm, cooler_on, state and fault all read 0 before the next clk edge.
